udp_byte_packer: RTL and testbench
==================================

// Module: udp_byte_packer
// PURPOSE
//  Packs a byte stream (UDP payload bytes from the parser) into BYTES_PER_WORD-wide words.
//  Generalises the fixed 32-bit "first byte in MSB, pad 0xFF" packing to any width, either
//  byte order and a programmable pad byte. Valid/ready on both sides; s_last closes a partial word.
//  Sits between the RX byte path and the word-wide packet buffer.
// PARAMETERS
//  BYTES_PER_WORD  4      lanes per output word (>=1); DATA_W = 8*BYTES_PER_WORD
//  FIRST_BYTE_MSB  1      1: first byte in lane [DATA_W-1 -: 8]; 0: first byte in lane [7:0]
//  PAD_BYTE        8'hFF  value placed in unfilled lanes of a partial (last) word
//  CNT_W           16     width of word_cnt
// PORTS
//  clk        in   1               single clock, all logic on posedge
//  reset      in   1               synchronous, active-high
//  s_data     in   8               input byte
//  s_valid    in   1               s_data valid
//  s_last     in   1               byte is final byte of packet
//  s_ready    out  1               byte accepted when s_valid & s_ready
//  m_data     out  DATA_W          packed word
//  m_keep     out  BYTES_PER_WORD  1 per lane holding real data (bit order follows lane order)
//  m_valid    out  1               m_data/m_keep/m_last valid
//  m_last     out  1               word contains final byte of packet
//  m_ready    in   1               word consumed when m_valid & m_ready
//  word_cnt   out  CNT_W           words emitted since reset, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset: m_valid=0, m_last=0, m_keep=0, m_data=all PAD_BYTE, word_cnt=0, lane idx=0,
//    accumulator filled with PAD_BYTE. Reset mid-packet discards partial word; nothing emitted.
//  - Structure: accumulator (lane idx 0..N-1, keep bits) + one output register (EMPTY/FULL).
//  - s_ready = ~m_valid | m_ready (combinational); no byte is ever dropped or duplicated.
//  - Accept byte k=idx: FIRST_BYTE_MSB=1 -> lane bits [DATA_W-1-8k -: 8], keep bit [N-1-k];
//    FIRST_BYTE_MSB=0 -> lane bits [8k+7:8k], keep bit [k].
//  - Word completes when accepted byte has idx==N-1 or s_last=1. On completion: output
//    register loaded next edge (m_valid=1, m_last=s_last, m_keep=acc keep), idx->0,
//    accumulator refilled with PAD_BYTE, keep cleared. Latency: completing byte -> m_valid 1 cycle.
//  - Non-completing byte: idx+1, output register unaffected.
//  - Output: m_data/m_keep/m_last held stable while m_valid & ~m_ready. On m_valid & m_ready
//    with no new completion: m_valid->0. Simultaneous drain + completion: new word loaded, m_valid stays 1.
//  - word_cnt increments on each m_valid & m_ready handshake; wraps silently.
//  - s_last with idx==N-1: single full word, m_last=1 (no extra empty word).
//  - BYTES_PER_WORD=1: every accepted byte emits a word, m_keep=1.
//  - Sustained throughput 1 byte/cycle while m_ready=1.
//  - s_data/s_last ignored when s_valid=0; m_keep never all-zero while m_valid=1.
// TESTING (N=4, FIRST_BYTE_MSB=1, PAD 0xFF, m_ready=1 unless noted)
//  1) bytes EF,AA,BB,CC, s_last on CC -> one word 0xEFAABBCC, keep 4'hF, last=1, 1 cycle after CC
//  2) single byte EF with s_last -> 0xEFFFFFFF, keep 4'b1000, last=1; word_cnt=1
//  3) bytes 01..09 back-to-back, last on 09 -> 0x01020304, 0x05060708, 0x09FFFFFF keep 1000 last; word_cnt=3
//  4) m_ready=0 for 5 cycles with word pending -> m_data stable, s_ready=0; release -> all bytes in order
//  5) FIRST_BYTE_MSB=0, N=2: bytes 12,34 last -> 0x3412, keep 2'b11; byte 56 last -> 0xFF56, keep 2'b01
//  6) reset after 2 bytes of packet -> m_valid=0, word_cnt=0; next packet AB,CD,EF,01 -> 0xABCDEF01

Source files
------------

// File: rtl/udp_byte_packer.sv
// Packs an accepted byte stream into BYTES_PER_WORD-lane words with keep bits.
// A closing byte (s_last) flushes a partial word, and its unfilled lanes hold PAD_BYTE.
module udp_byte_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter bit          FIRST_BYTE_MSB = 1'b1,
  parameter logic [7:0]  PAD_BYTE       = 8'hFF,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned DATA_W        = 8 * BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [BYTES_PER_WORD-1:0] m_keep,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [CNT_W-1:0]          word_cnt
);

  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [DATA_W-1:0] PAD_WORD = {BYTES_PER_WORD{PAD_BYTE}};

  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          lane;
  logic [DATA_W-1:0]         acc_data;
  logic [DATA_W-1:0]         ins_data;
  logic [BYTES_PER_WORD-1:0] acc_keep;
  logic [BYTES_PER_WORD-1:0] ins_keep;
  logic                      accept;
  logic                      complete;

  // The output register can always take a new word whenever it is being drained.
  assign s_ready  = ~m_valid | m_ready;
  assign accept   = s_valid & s_ready;
  assign complete = accept & (s_last | (idx == LAST_IDX));
  assign lane     = FIRST_BYTE_MSB ? (LAST_IDX - idx) : idx;

  // Accumulator contents with the incoming byte merged into its lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ins_data = acc_data;
    ins_keep = acc_keep;
    for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
      if (lane == IDX_W'(i)) begin
        ins_data[8*i +: 8] = s_data;
        ins_keep[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      idx      <= '0;
      acc_data <= PAD_WORD;
      acc_keep <= '0;
      m_data   <= PAD_WORD;
      m_keep   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      word_cnt <= '0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid  <= 1'b0;
        word_cnt <= word_cnt + 1'b1;
      end
      if (complete) begin
        m_data   <= ins_data;
        m_keep   <= ins_keep;
        m_last   <= s_last;
        m_valid  <= 1'b1;
        idx      <= '0;
        acc_data <= PAD_WORD;
        acc_keep <= '0;
      end else if (accept) begin
        idx      <= idx + 1'b1;
        acc_data <= ins_data;
        acc_keep <= ins_keep;
      end
    end
  end

endmodule

// File: tb/tb_udp_byte_packer.sv
// Directed bench: a 4-lane MSB-first packer driven from a vector table and by stall/reset
// sequences, plus a 2-lane LSB-first instance.
module tb_udp_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_ready;
  logic [15:0] word_cnt;

  logic [7:0]  b_s_data;
  logic        b_s_valid, b_s_last, b_s_ready;
  logic [15:0] b_m_data;
  logic [1:0]  b_m_keep;
  logic        b_m_valid, b_m_last, b_m_ready;
  logic [15:0] b_word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  udp_byte_packer dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .word_cnt(word_cnt)
  );

  udp_byte_packer #(.BYTES_PER_WORD(2), .FIRST_BYTE_MSB(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_keep(b_m_keep), .m_valid(b_m_valid), .m_last(b_m_last),
    .m_ready(b_m_ready), .word_cnt(b_word_cnt)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
  endtask

  task automatic b_send(input logic [7:0] d, input logic l);
    b_s_valid = 1'b1;
    b_s_data  = d;
    b_s_last  = l;
    step();
  endtask

  initial begin
    // Word shows up one edge after its closing byte; word_cnt counts the handshake one edge later.
    vecs[0]  = '{1'b1, 8'hEF, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 8'hCC, 1'b1, 1'b1, 32'hEFAABBCC, 4'hF, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 8'hEF, 1'b1, 1'b1, 32'hEFFFFFFF, 4'h8, 1'b1, 16'd1};
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 8'hEE, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd2};
    vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 16'd2};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    vecs[12] = '{1'b1, 8'h07, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 16'd3};
    vecs[13] = '{1'b1, 8'h08, 1'b0, 1'b1, 32'h05060708, 4'hF, 1'b0, 16'd3};
    vecs[14] = '{1'b1, 8'h09, 1'b1, 1'b1, 32'h09FFFFFF, 4'h8, 1'b1, 16'd4};

    reset = 1'b1;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    b_s_data = 8'h00; b_s_valid = 1'b0; b_s_last = 1'b0; b_m_ready = 1'b1;
    step();
    step();
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_keep", m_keep, 4'h0);
    check("rst_m_data", m_data, 32'hFFFFFFFF);
    check("rst_word_cnt", word_cnt, 16'd0);
    check("rst_s_ready", s_ready, 1'b1);
    reset = 1'b0;

    // Packets 1-3 with a s_valid=0 gap carrying junk data/last.
    for (int i = 0; i < 15; i++) begin
      s_valid = vecs[i].v;
      s_data  = vecs[i].d;
      s_last  = vecs[i].l;
      step();
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].ev);
      check($sformatf("vec%0d_word_cnt", i), word_cnt, vecs[i].ec);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_m_data", i), m_data, vecs[i].ed);
        check($sformatf("vec%0d_m_keep", i), m_keep, vecs[i].ek);
        check($sformatf("vec%0d_m_last", i), m_last, vecs[i].el);
      end
    end
    s_valid = 1'b0;
    step();
    check("drain_m_valid", m_valid, 1'b0);
    check("drain_word_cnt", word_cnt, 16'd5);

    // Backpressure: a full word held while m_ready=0 blocks the next byte.
    m_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    s_data = 8'h55;
    s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d_m_valid", i), m_valid, 1'b1);
      check($sformatf("stall%0d_m_data", i), m_data, 32'h11223344);
      check($sformatf("stall%0d_s_ready", i), s_ready, 1'b0);
    end
    check("stall_word_cnt", word_cnt, 16'd5);
    m_ready = 1'b1;
    #1;
    check("release_s_ready", s_ready, 1'b1);
    step();
    check("release_m_valid", m_valid, 1'b0);
    check("release_word_cnt", word_cnt, 16'd6);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    check("post_stall_m_valid", m_valid, 1'b1);
    check("post_stall_m_data", m_data, 32'h55667788);
    check("post_stall_m_keep", m_keep, 4'hF);
    check("post_stall_m_last", m_last, 1'b1);
    s_valid = 1'b0;
    step();
    check("post_stall_word_cnt", word_cnt, 16'd7);

    // Reset mid-packet discards the partial word.
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    s_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_word_cnt", word_cnt, 16'd0);
    check("midrst_m_keep", m_keep, 4'h0);
    send(8'hAB, 1'b0);
    check("midrst_no_early_word", m_valid, 1'b0);
    send(8'hCD, 1'b0);
    send(8'hEF, 1'b0);
    send(8'h01, 1'b1);
    check("midrst_m_valid2", m_valid, 1'b1);
    check("midrst_m_data", m_data, 32'hABCDEF01);
    check("midrst_m_keep2", m_keep, 4'hF);
    check("midrst_m_last", m_last, 1'b1);
    s_valid = 1'b0;
    step();

    // Two-lane, first byte in the low lane.
    b_send(8'h78, 1'b0);
    b_send(8'h9A, 1'b0);
    check("b_full_m_valid", b_m_valid, 1'b1);
    check("b_full_m_data", b_m_data, 16'h9A78);
    check("b_full_m_last", b_m_last, 1'b0);
    b_send(8'h12, 1'b0);
    b_send(8'h34, 1'b1);
    check("b_last_m_data", b_m_data, 16'h3412);
    check("b_last_m_keep", b_m_keep, 2'b11);
    check("b_last_m_last", b_m_last, 1'b1);
    b_send(8'h56, 1'b1);
    check("b_pad_m_valid", b_m_valid, 1'b1);
    check("b_pad_m_data", b_m_data, 16'hFF56);
    check("b_pad_m_keep", b_m_keep, 2'b01);
    check("b_pad_m_last", b_m_last, 1'b1);
    b_s_valid = 1'b0;
    step();
    check("b_drain_m_valid", b_m_valid, 1'b0);
    check("b_word_cnt", b_word_cnt, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
